popcount_stream: RTL and testbench

Streaming, parametrised population-count engine with valid/ready handshakes. Each accepted input word of `WIDTH` bits is reduced to its set-bit count through a registered pipeline. Counts are either emitted per word or accumulated across a multi-beat burst terminated by `in_last`. The block sits between a bit-vector producer, such as a sensor or scan-chain capture, and a consumer that reads counts at its own rate.

---
 rtl/popcount_stream.sv | 202 ++++++++++++++++++++
 tb/tb_popcount_stream.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_stream.sv
// popcount_stream: streaming population-count engine with valid/ready handshakes.
// Pipeline: S1 (popcount + beat register) -> S2 (IDLE/ACCUM FSM with result
// register) -> output register. A single global advance signal stalls every
// stage together whenever the output register holds an unconsumed result.
module popcount_stream #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_count,
  output logic             out_sat
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  // Set-bit count of one word; synthesises to an adder tree.
  function automatic logic [CNT_W-1:0] popcount_f(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = {CNT_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      c = c + {{(CNT_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Handshake and input-side signals
  logic             adv_s;
  logic             accept_s;
  logic             eff_mode_s;
  logic [ACC_W-1:0] cnt_ext_s;

  // S1 registers
  logic             s1_valid_r;
  logic [ACC_W-1:0] s1_cnt_r;
  logic             s1_last_r;
  logic             s1_mode_r;
  logic             burst_open_r;

  // S2 FSM and accumulator
  state_t           state_r;
  state_t           state_nxt_s;
  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] acc_nxt_s;
  logic             sat_r;
  logic             sat_nxt_s;
  logic [ACC_W:0]   sum_s;
  logic             ovf_s;
  logic [ACC_W-1:0] sum_clamp_s;
  logic             res_valid_s;
  logic [ACC_W-1:0] res_count_s;
  logic             res_sat_s;

  // S2 result register
  logic             s2_valid_r;
  logic [ACC_W-1:0] s2_count_r;
  logic             s2_sat_r;

  // Output register
  logic             out_valid_r;
  logic [ACC_W-1:0] out_count_r;
  logic             out_sat_r;

  // Global advance: the pipeline moves unless a result is waiting on the consumer.
  // A beat inside an open burst always inherits burst mode.
  always_comb begin
    adv_s      = ~out_valid_r | out_ready;
    accept_s   = in_valid & adv_s;
    eff_mode_s = burst_open_r | in_mode;
    cnt_ext_s  = ACC_W'(popcount_f(in_data));
  end

  assign in_ready  = adv_s;
  assign out_valid = out_valid_r;
  assign out_count = out_count_r;
  assign out_sat   = out_sat_r;

  // S1: register the word count, beat valid, last flag and effective mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_cnt_r   <= {ACC_W{1'b0}};
      s1_last_r  <= 1'b0;
      s1_mode_r  <= 1'b0;
    end else if (adv_s) begin
      s1_valid_r <= in_valid;
      s1_cnt_r   <= cnt_ext_s;
      s1_last_r  <= in_last;
      s1_mode_r  <= eff_mode_s;
    end
  end

  // Track whether a mode-1 burst is open on the input side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_open_r <= 1'b0;
    end else if (accept_s) begin
      if (in_last) begin
        burst_open_r <= 1'b0;
      end else if (eff_mode_s) begin
        burst_open_r <= 1'b1;
      end
    end
  end

  // Saturating burst sum of the running accumulator and the current beat count.
  always_comb begin
    sum_s       = {1'b0, acc_r} + {1'b0, s1_cnt_r};
    ovf_s       = sum_s[ACC_W];
    sum_clamp_s = ovf_s ? {ACC_W{1'b1}} : sum_s[ACC_W-1:0];
  end

  // S2 next-state, accumulator update and result generation.
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    sat_nxt_s   = sat_r;
    res_valid_s = 1'b0;
    res_count_s = s1_cnt_r;
    res_sat_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (s1_valid_r && s1_mode_r && !s1_last_r) begin
          acc_nxt_s   = s1_cnt_r;
          sat_nxt_s   = 1'b0;
          state_nxt_s = ST_ACCUM;
        end else if (s1_valid_r) begin
          res_valid_s = 1'b1;
          res_count_s = s1_cnt_r;
          res_sat_s   = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (s1_valid_r && s1_last_r) begin
          res_valid_s = 1'b1;
          res_count_s = sum_clamp_s;
          res_sat_s   = sat_r | ovf_s;
          acc_nxt_s   = {ACC_W{1'b0}};
          sat_nxt_s   = 1'b0;
          state_nxt_s = ST_IDLE;
        end else if (s1_valid_r) begin
          acc_nxt_s = sum_clamp_s;
          sat_nxt_s = sat_r | ovf_s;
        end else begin
          state_nxt_s = ST_ACCUM;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        acc_nxt_s   = {ACC_W{1'b0}};
        sat_nxt_s   = 1'b0;
      end
    endcase
  end

  // S2 state: FSM, accumulator, sticky saturation and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      acc_r      <= {ACC_W{1'b0}};
      sat_r      <= 1'b0;
      s2_valid_r <= 1'b0;
      s2_count_r <= {ACC_W{1'b0}};
      s2_sat_r   <= 1'b0;
    end else if (adv_s) begin
      state_r    <= state_nxt_s;
      acc_r      <= acc_nxt_s;
      sat_r      <= sat_nxt_s;
      s2_valid_r <= res_valid_s;
      s2_count_r <= res_count_s;
      s2_sat_r   <= res_sat_s;
    end
  end

  // Output register: reload on advance, hold stable while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_count_r <= {ACC_W{1'b0}};
      out_sat_r   <= 1'b0;
    end else if (adv_s) begin
      out_valid_r <= s2_valid_r;
      out_count_r <= s2_count_r;
      out_sat_r   <= s2_sat_r;
    end
  end

endmodule

// File: tb/tb_popcount_stream.sv
// Scoreboard bench for popcount_stream (WIDTH=8, ACC_W=8): directed beats push
// hand-computed results; a negedge monitor pops and compares on each emit.
module tb_popcount_stream;

  localparam int WIDTH = 8;
  localparam int ACC_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_count;
  logic             out_sat;

  typedef struct packed {
    logic [ACC_W-1:0] count;
    logic             sat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   pop_cyc[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  popcount_stream #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic void push(input int c, input bit s);
    exp_t e;
    e.count = ACC_W'(c);
    e.sat   = s;
    exp_q.push_back(e);
  endfunction

  // Drive one beat and return #1 after the edge that accepts it.
  task automatic send(input logic [WIDTH-1:0] d, input logic m, input logic l);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    in_last  = l;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready 0 for 200 cycles, expected 1");
    end
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_mode  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Monitor: every emit (out_valid & out_ready) must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got count %0d sat %0d, expected no output", out_count, out_sat);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_count", 32'(out_count), 32'(mon_e.count));
        check("out_sat", 32'(out_sat), 32'(mon_e.sat));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [ACC_W-1:0] held;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_mode   = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_sat", 32'(out_sat), 32'd0);

    // Latency: mode-0 beat (in_last ignored) visible after edge k+2
    push(6, 1'b0);
    send(8'h3F, 1'b0, 1'b1);
    idle();
    check("lat_k0", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_k1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_k2", 32'(out_valid), 32'd1);
    drain();

    // Mode 0 back-to-back words, results on consecutive cycles
    pop_cyc.delete();
    push(8, 1'b0); push(0, 1'b0); push(4, 1'b0);
    send(8'hFF, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    send(8'hA5, 1'b0, 1'b0);
    idle();
    drain();
    check("m0_num_results", 32'(pop_cyc.size()), 32'd3);
    if (pop_cyc.size() == 3) check("m0_consecutive", 32'(pop_cyc[2] - pop_cyc[0]), 32'd2);

    // Mode 1 burst followed immediately by a mode-0 word
    push(10, 1'b0); push(4, 1'b0);
    send(8'h0F, 1'b1, 1'b0);
    send(8'hF0, 1'b1, 1'b0);
    send(8'h81, 1'b1, 1'b1);
    send(8'hA5, 1'b0, 1'b0);
    idle();
    drain();

    // Saturating 33-beat burst (264 -> 255), then a fresh single-beat burst
    push(255, 1'b1); push(1, 1'b0);
    for (int i = 0; i < 32; i++) send(8'hFF, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b1);
    send(8'h01, 1'b1, 1'b1);
    idle();
    drain();

    // in_mode dropped mid-burst is ignored: 2 + 4 + 1
    push(7, 1'b0);
    send(8'h03, 1'b1, 1'b0);
    send(8'h0F, 1'b0, 1'b0);
    send(8'h01, 1'b1, 1'b1);
    idle();
    drain();

    // Consumer stall for 5 cycles with beats queued behind a pending result
    out_ready = 1'b0;
    push(3, 1'b0); push(6, 1'b0); push(1, 1'b0);
    fork
      begin
        send(8'h07, 1'b0, 1'b0);
        send(8'h3F, 1'b0, 1'b0);
        send(8'h01, 1'b0, 1'b0);
        idle();
      end
      begin
        for (int j = 0; j < 20 && !out_valid; j++) begin
          @(posedge clk); #1;
        end
        check("stall_valid", 32'(out_valid), 32'd1);
        held = out_count;
        check("stall_first", 32'(held), 32'd3);
        for (int j = 0; j < 5; j++) begin
          check("stall_in_ready", 32'(in_ready), 32'd0);
          check("stall_hold", 32'(out_count), 32'(held));
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset in the middle of an open burst discards it and closes the burst
    send(8'h11, 1'b1, 1'b0);
    send(8'h22, 1'b1, 1'b0);
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    push(4, 1'b0);
    send(8'h3C, 1'b0, 1'b0);
    idle();
    drain();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
